// File: rtl/ecc_s1d_encoder_pipe.sv
// SEC write-path encoder: 32-bit data -> 38-bit Hamming codeword, two registered stages.
// Optional single-bit error injection is compiled in with `define ECC_ERR_INJ_EN.
module ecc_s1d_encoder_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             di_vld,
    output logic             di_rdy,
    input  logic [31:0]      di,
    output logic             do_vld,
    input  logic             do_rdy,
    output logic [37:0]      dout,
    output logic [CNT_W-1:0] enc_cnt
`ifdef ECC_ERR_INJ_EN
    ,
    input  logic             inj_arm,
    input  logic [5:0]       inj_pos,
    output logic             inj_done
`endif
);

    // Handshake: a word moves on a side only in a cycle where vld & rdy are both 1 at the
    // rising edge; a producer holds vld and data stable until then, and rdy may depend on
    // nothing but the downstream rdy and internal state.
    logic        s1_vld;
    logic [31:0] s1_d;
    logic        s1_en;
    logic        s2_en;
    logic [5:0]  p;
    logic [37:0] cw;
    logic [37:0] flip;

    assign s2_en  = !do_vld || do_rdy;
    assign s1_en  = !s1_vld || s2_en;
    assign di_rdy = s1_en;

    always_comb begin
        p[0] = ^{s1_d[0], s1_d[1], s1_d[3], s1_d[4], s1_d[6], s1_d[8], s1_d[10],
                 s1_d[12], s1_d[14], s1_d[17], s1_d[19], s1_d[24], s1_d[28]};
        p[1] = ^{s1_d[0], s1_d[2], s1_d[3], s1_d[5], s1_d[6], s1_d[9], s1_d[11],
                 s1_d[12], s1_d[15], s1_d[18], s1_d[20], s1_d[22], s1_d[25], s1_d[29]};
        p[2] = ^{s1_d[1], s1_d[2], s1_d[3], s1_d[7], s1_d[8], s1_d[9], s1_d[13],
                 s1_d[14], s1_d[15], s1_d[21], s1_d[22], s1_d[26], s1_d[30]};
        p[3] = ^{s1_d[9:4], s1_d[18:16], s1_d[26:23], s1_d[31]};
        p[4] = ^{s1_d[18:10], s1_d[31:27]};
        p[5] = ^s1_d[31:19];
    end

    // Check bits sit at C0,C1,C3,C7,C14,C24; data fills the remaining positions in order.
    assign cw = {s1_d[31:19], p[5], s1_d[18:10], p[4], s1_d[9:4], p[3],
                 s1_d[3:1], p[2], s1_d[0], p[1], p[0]};

`ifdef ECC_ERR_INJ_EN
    logic       armed;
    logic [5:0] pos_q;
    logic       s1_tag;
    logic       tag_new;
    logic       load2;

    assign load2   = s1_vld && s2_en;
    assign tag_new = di_vld && s1_en && (inj_arm || (armed && !s1_tag));
    assign flip    = (s1_tag && pos_q < 6'd38) ? (38'(1) << pos_q) : 38'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            pos_q    <= 6'd0;
            s1_tag   <= 1'b0;
            inj_done <= 1'b0;
        end else begin
            if (inj_arm) begin
                armed <= 1'b1;
                pos_q <= inj_pos;
            end else if (load2 && s1_tag) begin
                armed <= 1'b0;
            end
            if (s1_en) s1_tag <= tag_new;
            inj_done <= load2 && s1_tag;
        end
    end
`else
    assign flip = 38'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_d    <= 32'd0;
            do_vld  <= 1'b0;
            dout    <= 38'd0;
            enc_cnt <= '0;
        end else begin
            if (s1_en) begin
                s1_vld <= di_vld;
                if (di_vld) s1_d <= di;
            end
            if (s2_en) begin
                do_vld <= s1_vld;
                if (s1_vld) dout <= cw ^ flip;
            end
            if (do_vld && do_rdy) enc_cnt <= enc_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ecc_s1d_encoder_pipe.sv
// Self-checking bench for ecc_s1d_encoder_pipe; the injection scenario needs ECC_ERR_INJ_EN.
module tb_ecc_s1d_encoder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        di_vld;
    logic        di_rdy;
    logic [31:0] di;
    logic        do_vld;
    logic        do_rdy;
    logic [37:0] dout;
    logic [15:0] enc_cnt;
`ifdef ECC_ERR_INJ_EN
    logic        inj_arm;
    logic [5:0]  inj_pos;
    logic        inj_done;
`endif

    int checks = 0;
    int errors = 0;
    logic [37:0] exp_q[$];
    logic [31:0] dat_q[$];
    logic        inj_q[$];
    int          cnt_exp = 0;
    int          inj_pend = -1;
    int          done_cnt = 0;
    int          full_seen = 0;
    logic        prev_stall = 1'b0;
    logic [37:0] prev_do = '0;
    logic [37:0] m_cw;
    logic [31:0] m_d;
    logic        m_f;

    always #5 clk = ~clk;

    ecc_s1d_encoder_pipe #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .di_vld(di_vld), .di_rdy(di_rdy), .di(di),
        .do_vld(do_vld), .do_rdy(do_rdy), .dout(dout), .enc_cnt(enc_cnt)
`ifdef ECC_ERR_INJ_EN
        , .inj_arm(inj_arm), .inj_pos(inj_pos), .inj_done(inj_done)
`endif
    );

    // Reference code: parity masks over D, check positions listed explicitly.
    function automatic logic [31:0] pmask(input int k);
        case (k)
            0: return 32'h110A_555B;
            1: return 32'h2254_9A6D;
            2: return 32'h4460_E38E;
            3: return 32'h8787_03F0;
            4: return 32'hF807_FC00;
            5: return 32'hFFF8_0000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_chk(input int i);
        return (i == 0 || i == 1 || i == 3 || i == 7 || i == 14 || i == 24);
    endfunction

    function automatic logic [37:0] encode(input logic [31:0] d);
        logic [37:0] c;
        int j, k;
        j = 0; k = 0; c = '0;
        for (int i = 0; i < 38; i++) begin
            if (is_chk(i)) begin c[i] = ^(d & pmask(k)); k++; end
            else begin c[i] = d[j]; j++; end
        end
        return c;
    endfunction

    function automatic logic [31:0] extract(input logic [37:0] c);
        logic [31:0] d;
        int j;
        j = 0; d = '0;
        for (int i = 0; i < 38; i++) if (!is_chk(i)) begin d[j] = c[i]; j++; end
        return d;
    endfunction

    function automatic logic [5:0] syndrome(input logic [37:0] c);
        logic [5:0]  s;
        logic [31:0] d;
        int k;
        d = extract(c); k = 0; s = '0;
        for (int i = 0; i < 38; i++) if (is_chk(i)) begin s[k] = c[i] ^ (^(d & pmask(k))); k++; end
        return s;
    endfunction

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (di_rdy !== !(exp_q.size() == 2 && !do_rdy)) begin
                errors++;
                $display("FAIL di_rdy: got %b want %b (inflight %0d do_rdy %b)", di_rdy,
                         !(exp_q.size() == 2 && !do_rdy), exp_q.size(), do_rdy);
            end
            if (di_rdy === 1'b0) full_seen++;
            if (prev_stall) begin
                checks++;
                if (do_vld !== 1'b1 || dout !== prev_do) begin
                    errors++;
                    $display("FAIL stall_hold: got vld %b do %h want vld 1 do %h", do_vld, dout, prev_do);
                end
            end
            if (do_vld === 1'b1 && do_rdy === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_do: got %h want no output", dout);
                end else begin
                    m_cw = exp_q.pop_front();
                    m_d  = dat_q.pop_front();
                    m_f  = inj_q.pop_front();
                    cnt_exp++;
                    if (dout !== m_cw) begin
                        errors++;
                        $display("FAIL codeword: got %h want %h", dout, m_cw);
                    end
                    checks++;
                    if ((syndrome(dout) != 6'd0) !== m_f) begin
                        errors++;
                        $display("FAIL syndrome: got %h want error flag %b", syndrome(dout), m_f);
                    end
                    checks++;
                    if (extract(dout) !== m_d) begin
                        errors++;
                        $display("FAIL ddo: got %h want %h", extract(dout), m_d);
                    end
                end
            end
`ifdef ECC_ERR_INJ_EN
            if (inj_done === 1'b1) done_cnt++;
`endif
            prev_stall = (do_vld === 1'b1) && (do_rdy !== 1'b1);
            prev_do    = dout;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete(); dat_q.delete(); inj_q.delete();
        cnt_exp = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        prev_stall = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Presents d until accepted; returns 1 time unit after the accepting edge with di_vld still 1.
    task automatic send_word(input logic [31:0] d);
        bit acc;
        logic [37:0] c;
        di = d; di_vld = 1'b1; acc = 1'b0;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            acc = di_rdy;
            @(posedge clk);
            if (acc) begin
                c = encode(d);
                if (inj_pend >= 0) begin
                    if (inj_pend < 38) c[inj_pend] = ~c[inj_pend];
                    inj_q.push_back(inj_pend < 38);
                    inj_pend = -1;
                end else inj_q.push_back(1'b0);
                exp_q.push_back(c);
                dat_q.push_back(d);
            end
            #1;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: got no di_rdy want accept within 300 cycles");
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && exp_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_rdy = 1'b1; di_vld = 1'b0; di = '0;
        rst_n = 1'b0;
        #2;
        checks++;
        if (do_vld !== 1'b0 || dout !== 38'd0 || enc_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got vld %b do %h cnt %0d want 0 0 0", do_vld, dout, enc_cnt);
        end
        do_reset();
        checks++;
        if (di_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy: got %b want 1", di_rdy);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] vd[3];
        logic [37:0] vc[3];
        vd[0] = 32'h0;          vc[0] = 38'h0;
        vd[1] = 32'h1;          vc[1] = 38'h7;
        vd[2] = 32'hFFFF_FFFF;  vc[2] = 38'h3F_FFFF_BF7D;
        for (int i = 0; i < 3; i++) begin
            send_word(vd[i]);
            di_vld = 1'b0;
            checks++;
            if (do_vld !== 1'b0) begin
                errors++;
                $display("FAIL latency_early %0d: got vld %b want 0", i, do_vld);
            end
            @(posedge clk); #1;
            checks++;
            if (do_vld !== 1'b1 || dout !== vc[i]) begin
                errors++;
                $display("FAIL vector %0d: got vld %b do %h want 1 %h", i, do_vld, dout, vc[i]);
            end
            drain();
            @(posedge clk); #1;
            checks++;
            if (enc_cnt !== 16'(i + 1)) begin
                errors++;
                $display("FAIL enc_cnt_vec %0d: got %0d want %0d", i, enc_cnt, i + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int run;
        do_reset();
        do_rdy = 1'b1;
        run = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) send_word($urandom);
                di_vld = 1'b0;
            end
            begin
                for (int t = 0; t < 50; t++) begin
                    @(negedge clk);
                    if (do_vld === 1'b1) break;
                end
                while (do_vld === 1'b1 && run < 200) begin
                    run++;
                    @(negedge clk);
                end
            end
        join
        checks++;
        if (run != 100) begin
            errors++;
            $display("FAIL contiguous: got run %0d want 100", run);
        end
        drain();
        @(posedge clk); #1;
        checks++;
        if (enc_cnt !== 16'd100) begin
            errors++;
            $display("FAIL enc_cnt_b2b: got %0d want 100", enc_cnt);
        end
    endtask

    task automatic test_stall();
        bit drv_done;
        drv_done = 1'b0;
        full_seen = 0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    send_word($urandom);
                    if ($urandom_range(0, 3) == 0) begin
                        di_vld = 1'b0;
                        repeat ($urandom_range(1, 2)) @(posedge clk);
                        #1;
                    end
                end
                di_vld = 1'b0;
                drv_done = 1'b1;
            end
            begin
                for (int t = 0; t < 3000 && !(drv_done && exp_q.size() == 0); t++) begin
                    @(posedge clk); #1;
                    do_rdy = 1'($urandom_range(0, 1));
                end
                do_rdy = 1'b1;
            end
        join
        drain();
        @(posedge clk); #1;
        checks++;
        if (enc_cnt !== 16'(cnt_exp)) begin
            errors++;
            $display("FAIL enc_cnt_stall: got %0d want %0d", enc_cnt, cnt_exp);
        end
        checks++;
        if (full_seen == 0) begin
            errors++;
            $display("FAIL backpressure: got no di_rdy low want at least one");
        end
    endtask

`ifdef ECC_ERR_INJ_EN
    task automatic test_inject();
        do_rdy = 1'b1;
        done_cnt = 0;
        inj_arm = 1'b1; inj_pos = 6'd14; inj_pend = 14;
        send_word(32'h0);
        inj_arm = 1'b0; di_vld = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dout !== 38'h4000 || inj_done !== 1'b1) begin
            errors++;
            $display("FAIL inject14: got do %h done %b want 4000 1", dout, inj_done);
        end
        drain();
        send_word(32'h0);
        di_vld = 1'b0;
        drain();
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL inj_done_count: got %0d want 1", done_cnt);
        end
        inj_arm = 1'b1; inj_pos = 6'd40; inj_pend = 40;
        @(posedge clk); #1;
        inj_arm = 1'b0;
        send_word(32'hA5A5_5A5A);
        di_vld = 1'b0;
        drain();
        checks++;
        if (done_cnt != 2) begin
            errors++;
            $display("FAIL inj_out_of_range: got %0d pulses want 2", done_cnt);
        end
    endtask
`endif

    task automatic test_reset_midflight();
        logic [31:0] d;
        do_rdy = 1'b0;
        send_word($urandom);
        send_word($urandom);
        di_vld = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (do_vld !== 1'b1 || di_rdy !== 1'b0) begin
            errors++;
            $display("FAIL prefill: got vld %b rdy %b want 1 0", do_vld, di_rdy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (do_vld !== 1'b0 || dout !== 38'd0 || enc_cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: got vld %b do %h cnt %0d want 0 0 0", do_vld, dout, enc_cnt);
        end
        do_reset();
        do_rdy = 1'b1;
        d = $urandom;
        send_word(d);
        di_vld = 1'b0;
        checks++;
        if (do_vld !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_early: got vld %b want 0", do_vld);
        end
        @(posedge clk); #1;
        checks++;
        if (do_vld !== 1'b1 || dout !== encode(d)) begin
            errors++;
            $display("FAIL post_reset_word: got vld %b do %h want 1 %h", do_vld, dout, encode(d));
        end
        drain();
    endtask

    initial begin
`ifdef ECC_ERR_INJ_EN
        inj_arm = 1'b0; inj_pos = 6'd0;
`endif
        test_reset();
        test_vectors();
        test_back_to_back();
        test_stall();
`ifdef ECC_ERR_INJ_EN
        test_inject();
`endif
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
